// File: rtl/qsys_shield_pio_seq.sv
// Avalon-MM pattern sequencer for the 26-bit shield PIO.
// The CPU loads a pattern table, OE word and step delay over the config slave, then
// starts the block. It writes OE once, then walks the table writing each entry to the
// PIO data register. It reads the pins back after each step and then idles DLY cycles.
module qsys_shield_pio_seq #(
   parameter int DEPTH = 16,
   parameter int DLY_W = 16
) (
   input  logic        csi_MCLK_clk,
   input  logic        rsi_MRST_reset,
   input  logic [4:0]  avs_ctrl_address,
   input  logic [31:0] avs_ctrl_writedata,
   output logic [31:0] avs_ctrl_readdata,
   input  logic        avs_ctrl_write,
   input  logic        avs_ctrl_read,
   output logic        avs_ctrl_waitrequest,
   output logic [4:0]  avm_gpio_address,
   output logic [31:0] avm_gpio_writedata,
   input  logic [31:0] avm_gpio_readdata,
   output logic [3:0]  avm_gpio_byteenable,
   output logic        avm_gpio_write,
   output logic        avm_gpio_read,
   input  logic        avm_gpio_waitrequest,
   output logic        ins_INTRQ_irq
);

   // state  | meaning
   // IDLE   | no run in progress, waiting for START
   // WR_OE  | writing the OE shadow to PIO addr 1
   // WR_DAT | writing table[idx] to PIO addr 0
   // RD_IN  | reading PIO addr 0 back into SAMPLE
   // WAIT   | counting the step delay down to terminal count
   typedef enum logic [2:0] {S_IDLE, S_WR_OE, S_WR_DAT, S_RD_IN, S_WAIT} state_t;

   state_t            state;
   logic              loop_en, irq_en, done, abort, stop_pend;
   logic [3:0]        len, len_sh, idx, nxt_idx;
   logic [31:0]       oe, oe_sh, sample;
   logic [DLY_W-1:0]  dly, dly_sh, cnt;
   logic [31:0]       tbl [DEPTH];
   logic              wr_ctrl, wr_stat, start_req, stop_req, stop_now, last_step, adv, busy;
   logic              unused_rd;

   assign unused_rd            = avs_ctrl_read;
   assign avs_ctrl_waitrequest = 1'b0;
   assign avm_gpio_byteenable  = 4'hF;
   assign busy                 = (state != S_IDLE);
   assign ins_INTRQ_irq        = irq_en & done;

   // Decode config strobes and the end-of-step condition shared by RD_IN and WAIT.
   always_comb begin
      wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == 5'd0);
      wr_stat   = avs_ctrl_write && (avs_ctrl_address == 5'd1);
      stop_req  = wr_ctrl && avs_ctrl_writedata[1];
      start_req = wr_ctrl && avs_ctrl_writedata[0] && !avs_ctrl_writedata[1];
      stop_now  = stop_pend || stop_req;
      last_step = (idx == len_sh);
      nxt_idx   = last_step ? 4'd0 : idx + 4'd1;
      adv       = !stop_now &&
                  (((state == S_RD_IN) && !avm_gpio_waitrequest && (dly_sh == '0)) ||
                   ((state == S_WAIT) && (cnt == '0)));
   end

   // CPU-visible configuration registers and pattern table.
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         loop_en <= 1'b0;
         irq_en  <= 1'b0;
         len     <= '0;
         oe      <= '0;
         dly     <= '0;
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      end else if (avs_ctrl_write) begin
         if (avs_ctrl_address[4]) begin
            tbl[avs_ctrl_address[3:0]] <= avs_ctrl_writedata;
         end else begin
            case (avs_ctrl_address[3:0])
               4'd0: begin
                  loop_en <= avs_ctrl_writedata[2];
                  irq_en  <= avs_ctrl_writedata[3];
               end
               4'd2:    len <= avs_ctrl_writedata[3:0];
               4'd3:    oe  <= avs_ctrl_writedata;
               4'd4:    dly <= avs_ctrl_writedata[DLY_W-1:0];
               default: ;
            endcase
         end
      end
   end

   // Zero-wait-state config readback.
   always_comb begin
      avs_ctrl_readdata = '0;
      if (avs_ctrl_address[4]) begin
         avs_ctrl_readdata = tbl[avs_ctrl_address[3:0]];
      end else begin
         case (avs_ctrl_address[3:0])
            4'd0:    avs_ctrl_readdata = {28'd0, irq_en, loop_en, 2'b00};
            4'd1:    avs_ctrl_readdata = {20'd0, idx, 5'd0, abort, done, busy};
            4'd2:    avs_ctrl_readdata = {28'd0, len};
            4'd3:    avs_ctrl_readdata = oe;
            4'd4:    avs_ctrl_readdata = 32'(dly);
            4'd5:    avs_ctrl_readdata = sample;
            default: avs_ctrl_readdata = '0;
         endcase
      end
   end

   // Sequencer FSM with registered master outputs; STOP is only honoured once the
   // current bus transfer has been accepted so strobes never drop under waitrequest.
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         state              <= S_IDLE;
         idx                <= '0;
         len_sh             <= '0;
         oe_sh              <= '0;
         dly_sh             <= '0;
         cnt                <= '0;
         sample             <= '0;
         done               <= 1'b0;
         abort              <= 1'b0;
         stop_pend          <= 1'b0;
         avm_gpio_address   <= '0;
         avm_gpio_writedata <= '0;
         avm_gpio_write     <= 1'b0;
         avm_gpio_read      <= 1'b0;
      end else begin
         if (wr_stat && avs_ctrl_writedata[1]) done  <= 1'b0;
         if (wr_stat && avs_ctrl_writedata[2]) abort <= 1'b0;
         if (stop_req && busy) stop_pend <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start_req) begin
                  len_sh             <= len;
                  oe_sh              <= oe;
                  dly_sh             <= dly;
                  idx                <= '0;
                  avm_gpio_address   <= 5'd1;
                  avm_gpio_writedata <= oe;
                  avm_gpio_write     <= 1'b1;
                  state              <= S_WR_OE;
               end
            end
            S_WR_OE: begin
               if (!avm_gpio_waitrequest) begin
                  if (stop_now) begin
                     avm_gpio_write <= 1'b0;
                     abort          <= 1'b1;
                     stop_pend      <= 1'b0;
                     state          <= S_IDLE;
                  end else begin
                     avm_gpio_address   <= 5'd0;
                     avm_gpio_writedata <= tbl[0];
                     state              <= S_WR_DAT;
                  end
               end
            end
            S_WR_DAT: begin
               if (!avm_gpio_waitrequest) begin
                  avm_gpio_write <= 1'b0;
                  if (stop_now) begin
                     abort     <= 1'b1;
                     stop_pend <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     avm_gpio_read <= 1'b1;
                     state         <= S_RD_IN;
                  end
               end
            end
            S_RD_IN: begin
               if (!avm_gpio_waitrequest) begin
                  sample        <= avm_gpio_readdata;
                  avm_gpio_read <= 1'b0;
                  if (stop_now) begin
                     abort     <= 1'b1;
                     stop_pend <= 1'b0;
                     state     <= S_IDLE;
                  end else if (dly_sh != '0) begin
                     cnt   <= dly_sh - DLY_W'(1);
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (stop_now) begin
                  abort     <= 1'b1;
                  stop_pend <= 1'b0;
                  state     <= S_IDLE;
               end else if (cnt != '0) begin
                  cnt <= cnt - DLY_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase

         // End of a step: wrap or advance to the next entry, or finish the run.
         if (adv) begin
            if (last_step && !loop_en) begin
               done  <= 1'b1;
               state <= S_IDLE;
            end else begin
               idx                <= nxt_idx;
               avm_gpio_address   <= 5'd0;
               avm_gpio_writedata <= tbl[nxt_idx];
               avm_gpio_write     <= 1'b1;
               state              <= S_WR_DAT;
            end
         end
      end
   end

endmodule

// File: tb/tb_qsys_shield_pio_seq.sv
// Testbench for qsys_shield_pio_seq: a PIO slave model with programmable stalls feeds a
// scoreboard that compares every accepted master transfer against a queue of expected
// transfers built from the run configuration.
module tb_qsys_shield_pio_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  s_addr = '0;
   logic [31:0] s_wdata = '0;
   logic [31:0] s_rdata;
   logic        s_wr = 1'b0, s_rd = 1'b0, s_wait;
   logic [4:0]  m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata = '0;
   logic [3:0]  m_be;
   logic        m_wr, m_rd;
   logic        m_wait = 1'b0;
   logic        irq;

   qsys_shield_pio_seq dut (
      .csi_MCLK_clk         (clk),
      .rsi_MRST_reset       (rst),
      .avs_ctrl_address     (s_addr),
      .avs_ctrl_writedata   (s_wdata),
      .avs_ctrl_readdata    (s_rdata),
      .avs_ctrl_write       (s_wr),
      .avs_ctrl_read        (s_rd),
      .avs_ctrl_waitrequest (s_wait),
      .avm_gpio_address     (m_addr),
      .avm_gpio_writedata   (m_wdata),
      .avm_gpio_readdata    (m_rdata),
      .avm_gpio_byteenable  (m_be),
      .avm_gpio_write       (m_wr),
      .avm_gpio_read        (m_rd),
      .avm_gpio_waitrequest (m_wait),
      .ins_INTRQ_irq        (irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          is_wr;
      logic [4:0]  addr;
      logic [31:0] data;
      int          gap;
   } xfer_t;

   xfer_t       expq[$];
   logic [31:0] tblm [16];
   int          last_evt = 0;
   int          stall_mode = 0;
   bit          rd_fixed = 0;
   logic [31:0] rd_fixed_val = '0;
   logic [31:0] last_rd = '0;
   bit          in_xfer = 0, have_prev = 0;
   int          left = 0;
   logic        p_wr, p_rd;
   logic [4:0]  p_addr;
   logic [31:0] p_wdata;

   function automatic int pick_stall();
      case (stall_mode)
         0:       return 0;
         1:       return 3;
         2:       return int'($urandom_range(0, 2));
         default: return (m_wr && m_addr == 5'd0) ? 1000 : 0;
      endcase
   endfunction

   // Pop the next expected transfer and compare it with the one being accepted.
   task automatic accept();
      xfer_t e;
      int    gap;
      gap      = cyc + 1 - last_evt;
      last_evt = cyc + 1;
      if (m_rd) last_rd = m_rdata;
      if (expq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_xfer actual addr=%h wr=%b data=%h required none", m_addr, m_wr, m_wdata);
      end else begin
         e = expq.pop_front();
         chk("xfer_kind", {30'd0, m_wr, m_rd}, {30'd0, e.is_wr, !e.is_wr});
         chk("xfer_addr", {27'd0, m_addr}, {27'd0, e.addr});
         if (e.is_wr) chk("xfer_wdata", m_wdata, e.data);
         if (e.gap >= 0) chk("xfer_gap", gap, e.gap);
      end
   endtask

   // PIO slave model and monitor: decides waitrequest for the coming edge, checks
   // stability through stalls, and scores transfers that will be accepted.
   always @(negedge clk) begin
      if (rst) begin
         in_xfer   = 0;
         have_prev = 0;
         left      = 0;
         m_wait    = 1'b0;
      end else if (m_wr || m_rd) begin
         if (have_prev) begin
            chk("stall_strobes", {30'd0, m_wr, m_rd}, {30'd0, p_wr, p_rd});
            chk("stall_addr", {27'd0, m_addr}, {27'd0, p_addr});
            chk("stall_wdata", m_wdata, p_wdata);
         end
         if (!in_xfer) begin
            in_xfer = 1;
            left    = pick_stall();
            m_rdata = rd_fixed ? rd_fixed_val : ($urandom() & 32'h03FF_FFFF);
         end
         if (left > 0) begin
            m_wait    = 1'b1;
            left--;
            have_prev = 1;
            p_wr      = m_wr;
            p_rd      = m_rd;
            p_addr    = m_addr;
            p_wdata   = m_wdata;
         end else begin
            m_wait    = 1'b0;
            in_xfer   = 0;
            have_prev = 0;
            accept();
         end
      end else begin
         m_wait    = 1'b0;
         in_xfer   = 0;
         have_prev = 0;
      end
   end

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      s_addr  = a;
      s_wdata = d;
      s_wr    = 1'b1;
      @(posedge clk);
      #1 s_wr = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      s_addr = a;
      s_rd   = 1'b1;
      #1 d   = s_rdata;
      s_rd   = 1'b0;
   endtask

   task automatic start(input logic [31:0] ctrl);
      @(negedge clk);
      s_addr   = 5'd0;
      s_wdata  = ctrl | 32'h1;
      s_wr     = 1'b1;
      last_evt = cyc + 1;
      @(posedge clk);
      #1 s_wr = 1'b0;
   endtask

   task automatic load_table(input int n);
      for (int i = 0; i < n; i++) wr(5'(16 + i), tblm[i]);
   endtask

   // Expected transfer list for a run: OE once, then (data write, readback) per entry.
   // Gap = edges since the previous accepted transfer (or the START edge); -1 = unchecked.
   task automatic push_run(input int len, input logic [31:0] oe, input int dly,
                           input int s, input int loops);
      int g;
      int gw;
      xfer_t e;
      g = (s < 0) ? -1 : 1 + s;
      e = '{1'b1, 5'd1, oe, g};
      expq.push_back(e);
      for (int k = 0; k < loops; k++) begin
         for (int i = 0; i <= len; i++) begin
            gw = (s < 0) ? -1 : ((k == 0 && i == 0) ? 1 + s : 1 + s + dly);
            e  = '{1'b1, 5'd0, tblm[i], gw};
            expq.push_back(e);
            e  = '{1'b0, 5'd0, 32'd0, g};
            expq.push_back(e);
         end
      end
   endtask

   task automatic wait_idle(input string name);
      logic [31:0] st;
      bit ok;
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
         rd(5'd1, st);
         if (!st[0]) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s actual=busy required=idle within 4000 polls", name);
      end
   endtask

   task automatic end_of_run(input string name, input logic [2:0] stat_exp);
      logic [31:0] d;
      wait_idle(name);
      chk({name, "_drained"}, expq.size(), 0);
      rd(5'd1, d);
      chk({name, "_stat"}, {29'd0, d[2:0]}, {29'd0, stat_exp});
      rd(5'd5, d);
      chk({name, "_sample"}, d, last_rd);
   endtask

   logic [31:0] d;
   int          len, dly;
   logic [31:0] oe;

   initial begin
      #600000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_strobes", {30'd0, m_wr, m_rd}, 32'd0);
      chk("rst_maddr", {27'd0, m_addr}, 32'd0);
      chk("rst_mwdata", m_wdata, 32'd0);
      chk("rst_be", {28'd0, m_be}, 32'hF);
      chk("rst_swait", {31'd0, s_wait}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 6; a++) begin
         rd(5'(a), d);
         chk("rst_reg", d, 32'd0);
      end
      rd(5'd21, d);
      chk("rst_tbl", d, 32'd0);

      // Directed run, no stalls
      tblm[0] = 32'h1; tblm[1] = 32'h2; tblm[2] = 32'h4;
      load_table(3);
      wr(5'd2, 32'd2);
      wr(5'd3, 32'h03FF_FFFF);
      wr(5'd4, 32'd0);
      rd(5'd17, d);
      chk("tbl_readback", d, 32'h2);
      push_run(2, 32'h03FF_FFFF, 0, 0, 1);
      start(32'h0);
      end_of_run("t1", 3'b010);

      // Same run with three stall cycles on every transfer
      wr(5'd1, 32'h6);
      stall_mode = 1;
      push_run(2, 32'h03FF_FFFF, 0, 3, 1);
      start(32'h0);
      end_of_run("t2", 3'b010);
      stall_mode = 0;

      // Looping single entry with delay 5, stopped mid-WAIT
      wr(5'd1, 32'h6);
      tblm[0] = 32'h0155_AA33;
      load_table(1);
      wr(5'd2, 32'd0);
      wr(5'd4, 32'd5);
      push_run(0, 32'h03FF_FFFF, 5, 0, 3);
      start(32'h4);
      rd(5'd0, d);
      chk("ctrl_readback", d, 32'h4);
      for (int i = 0; i < 500 && expq.size() != 0; i++) @(negedge clk);
      chk("t3_drained", expq.size(), 0);
      wr(5'd0, 32'h6);
      rd(5'd1, d);
      chk("t3_stop_stat", {29'd0, d[2:0]}, 32'b100);
      repeat (12) @(negedge clk);
      rd(5'd1, d);
      chk("t3_stays_idle", {29'd0, d[2:0]}, 32'b100);
      wr(5'd1, 32'h4);
      rd(5'd1, d);
      chk("t3_abort_w1c", {29'd0, d[2:0]}, 32'd0);

      // Done interrupt
      wr(5'd4, 32'd0);
      push_run(0, 32'h03FF_FFFF, 0, 0, 1);
      start(32'h8);
      end_of_run("t4", 3'b010);
      chk("t4_irq_set", {31'd0, irq}, 32'd1);
      wr(5'd1, 32'h2);
      chk("t4_irq_clr", {31'd0, irq}, 32'd0);

      // Readback capture, START and config writes while busy
      rd_fixed     = 1;
      rd_fixed_val = 32'h00AB_CDEF;
      for (int i = 0; i < 4; i++) tblm[i] = $urandom() & 32'h03FF_FFFF;
      load_table(4);
      oe = $urandom() & 32'h03FF_FFFF;
      wr(5'd2, 32'd3);
      wr(5'd3, oe);
      wr(5'd4, 32'd20);
      push_run(3, oe, 20, 0, 1);
      start(32'h0);
      for (int i = 0; i < 200 && expq.size() > 4; i++) @(negedge clk);
      wr(5'd2, 32'd0);
      wr(5'd4, 32'd0);
      wr(5'd0, 32'd1);
      rd(5'd1, d);
      chk("t5_busy_idx", {20'd0, d[11:8], 7'd0, d[0]}, {20'd0, 4'd1, 7'd0, 1'b1});
      end_of_run("t5", 3'b010);
      rd(5'd5, d);
      chk("t5_sample", d, 32'h00AB_CDEF);
      rd(5'd2, d);
      chk("t5_len_accepted", d, 32'd0);
      rd_fixed = 0;

      // Randomised runs
      for (int r = 0; r < 6; r++) begin
         wr(5'd1, 32'h6);
         len = int'($urandom_range(0, 15));
         dly = int'($urandom_range(0, 3));
         oe  = $urandom() & 32'h03FF_FFFF;
         for (int i = 0; i < 16; i++) tblm[i] = $urandom() & 32'h03FF_FFFF;
         load_table(16);
         wr(5'd2, 32'(len));
         wr(5'd3, oe);
         wr(5'd4, 32'(dly));
         stall_mode = (r % 2 == 1) ? 2 : 0;
         push_run(len, oe, dly, (stall_mode == 0) ? 0 : -1, 1);
         start(32'h0);
         end_of_run("rand", 3'b010);
      end
      stall_mode = 0;

      // Reset while a data write is stalled
      wr(5'd1, 32'h6);
      wr(5'd2, 32'd1);
      wr(5'd4, 32'd2);
      stall_mode = 3;
      push_run(0, oe, 2, 0, 0);
      start(32'h8);
      for (int i = 0; i < 50 && !(m_wr && m_addr == 5'd0 && m_wait); i++) @(negedge clk);
      chk("t6_stalled", {31'd0, m_wr && m_wait}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_strobes", {30'd0, m_wr, m_rd}, 32'd0);
      chk("t6_maddr", {27'd0, m_addr}, 32'd0);
      chk("t6_mwdata", m_wdata, 32'd0);
      chk("t6_irq", {31'd0, irq}, 32'd0);
      for (int a = 0; a < 6; a++) begin
         rd(5'(a), d);
         chk("t6_reg", d, 32'd0);
      end
      rd(5'd16, d);
      chk("t6_tbl", d, 32'd0);
      expq.delete();
      stall_mode = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_quiet", {30'd0, m_wr, m_rd}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
